pipe_perf_counter: RTL and testbench
====================================

Name: pipe_perf_counter

Overview:
Synthesizable pipeline performance monitor. It counts run cycles and N_EVT independent per-cycle event strobes, such as stall, flush, branch and retire, produced by the CPU hazard and control logic. It sits beside the CPU core and replaces bench-side stall/flush counting. It adds three things bench counting lacks: saturating counters, a programmable auto-stop cycle limit, and a coherent snapshot/readout port.

Parameters:
CNT_W, 32, width of every counter (cycle and event); minimum 2.
N_EVT, 4, number of event channels; range 1..15.
MAX_CYCLES, 30, run-cycle limit that forces DONE; 0 = unlimited.
SEL_W, 4, snapshot select width; must satisfy 2**SEL_W >= N_EVT+1.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  reset, asynchronous, active-low.
start_i  in  1  level; high = count, low = pause.
clear_i  in  1  synchronous clear of counters, flags and shadows; returns FSM to IDLE.
evt_i  in  N_EVT  per-cycle event strobes; bit k increments channel k.
snap_req_i  in  1  pulse; captures all counters into shadow registers.
snap_sel_i  in  SEL_W  shadow select: 0..N_EVT-1 = event k, N_EVT = cycle counter.
snap_data_o  out  CNT_W  selected shadow value (combinational from shadow and sel).
snap_valid_o  out  1  shadows hold a capture since the last clear or reset.
cycle_o  out  CNT_W  live run-cycle count.
running_o  out  1  FSM in RUN.
done_o  out  1  FSM in DONE.
sat_o  out  N_EVT+1  sticky saturation flags; bit N_EVT belongs to the cycle counter.

Behaviour:
- Reset (rst_i=0, asynchronous): FSM=IDLE; all counters, shadows and sat_o cleared; snap_valid_o=0; all outputs 0.
- FSM states are IDLE, RUN and DONE. Encoding is free; only running_o and done_o are visible.
- IDLE -> RUN on an edge with start_i=1. IDLE holds counters (pause semantics).
- RUN -> IDLE on an edge with start_i=0.
- RUN -> DONE on the edge where cycle_cnt becomes MAX_CYCLES (MAX_CYCLES != 0). DONE ignores start_i.
- DONE -> IDLE only via clear_i or reset.
- Counting happens on each edge while the FSM is RUN before the edge:
  - cycle_cnt += 1.
  - evt_cnt[k] += evt_i[k].
  - The edge that moves IDLE->RUN does not count; the edge that moves RUN->IDLE/DONE does count.
- Saturation: a counter at 2**CNT_W-1 holds its value; its sat_o bit sets and stays set until clear_i or reset. No wrap-around is ever allowed.
- cycle_cnt saturating while MAX_CYCLES > 2**CNT_W-1 keeps the FSM in RUN indefinitely. This is legal; flag via sat_o[N_EVT].
- Snapshot: on an edge with snap_req_i=1, each shadow takes the counter's pre-edge value (the value before that edge's increment).
  - snap_valid_o=1 from the next cycle, held until clear or reset.
  - snap_req_i is honoured in any FSM state.
  - A new request overwrites the shadows.
- snap_sel_i > N_EVT -> snap_data_o = 0.
- Priority on a single edge: reset > clear_i > snap_req_i/counting. Snapshot and counting occur together.
- clear_i=1 with snap_req_i=1: clear wins; shadows=0, snap_valid_o=0.
- clear_i with start_i=1: the next state is IDLE. It enters RUN one edge later if start_i is still high.
- evt_i is sampled only in RUN; strobes in IDLE or DONE are ignored.

Test Plan:
1. Reset: hold rst_i=0 with start_i=1 and evt_i=all 1 -> all outputs 0. Release mid-cycle -> running_o=1 after the first edge; cycle_o=0 at that point.
2. Limit: MAX_CYCLES=30, start_i=1, evt_i[0]=1 every cycle, evt_i[1]=1 every third cycle.
   - Expected at done_o=1: cycle_o=30, evt0=30, evt1=10 (read via snapshot).
   - 5 further edges -> values unchanged.
3. Pause: run 7 edges, start_i=0 for 4 edges, start_i=1 for 3 edges -> cycle_o=10, running_o low during the pause.
4. Saturation: CNT_W=4, MAX_CYCLES=0, evt_i[2]=1, 20 run edges -> cycle_o=15, evt2=15, sat_o[2]=1, sat_o[N_EVT]=1, others 0.
5. Snapshot: pulse snap_req_i while cycle_o=12 in RUN, with evt_i[0] high on every run edge.
   - sel=N_EVT -> 12 and sel=0 -> 12, both stable while live counters advance; snap_valid_o=1.
   - sel=N_EVT+1 -> 0.
6. Conflict and async reset:
   - clear_i and snap_req_i on the same edge -> snap_valid_o=0, shadows 0, FSM IDLE.
   - Assert rst_i=0 between edges mid-RUN -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_perf_counter.sv
// Pipeline performance monitor: saturating run-cycle and per-event counters with
// an optional auto-stop cycle limit and a coherent shadow snapshot readout.
module pipe_perf_counter #(
    parameter int CNT_W      = 32,
    parameter int N_EVT      = 4,
    parameter int MAX_CYCLES = 30,
    parameter int SEL_W      = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic [N_EVT-1:0]   evt_i,
    input  logic               snap_req_i,
    input  logic [SEL_W-1:0]   snap_sel_i,
    output logic [CNT_W-1:0]   snap_data_o,
    output logic               snap_valid_o,
    output logic [CNT_W-1:0]   cycle_o,
    output logic               running_o,
    output logic               done_o,
    output logic [N_EVT:0]     sat_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // A limit wider than the counter can never be reached; the FSM then stays in RUN.
    localparam bit               LIMIT_ON  = (MAX_CYCLES != 0) && ($clog2(MAX_CYCLES + 1) <= CNT_W);
    localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(MAX_CYCLES);

    // Channel N_EVT is the cycle counter; it shares the event channel datapath.
    logic [CNT_W-1:0] r_cnt      [0:N_EVT];
    logic [CNT_W-1:0] r_shadow   [0:N_EVT];
    logic [CNT_W-1:0] w_cnt_next [0:N_EVT];
    logic [N_EVT:0]   r_sat;
    logic [N_EVT:0]   w_sat_next;
    logic [N_EVT:0]   w_inc;
    logic [N_EVT:0]   w_at_max;
    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_valid;
    logic             w_count;

    assign w_count = (r_state == ST_RUN);

    generate
        for (genvar gi = 0; gi <= N_EVT; gi++) begin : g_chan
            if (gi < N_EVT) begin : g_evt
                assign w_inc[gi] = evt_i[gi];
            end else begin : g_cyc
                assign w_inc[gi] = 1'b1;
            end
            assign w_at_max[gi]   = (r_cnt[gi] == CNT_MAX);
            assign w_cnt_next[gi] = (w_count && w_inc[gi] && !w_at_max[gi]) ?
                                    r_cnt[gi] + CNT_W'(1) : r_cnt[gi];
            assign w_sat_next[gi] = r_sat[gi] | (w_count & w_inc[gi] & w_at_max[gi]);
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start_i) w_state_next = ST_RUN;
            ST_RUN: begin
                if (LIMIT_ON && (w_cnt_next[N_EVT] == LIMIT_VAL)) w_state_next = ST_DONE;
                else if (!start_i)                                w_state_next = ST_IDLE;
            end
            ST_DONE: w_state_next = ST_DONE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_sat   <= '0;
            for (int i = 0; i <= N_EVT; i++) begin
                r_cnt[i]    <= '0;
                r_shadow[i] <= '0;
            end
        end else if (clear_i) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_sat   <= '0;
            for (int i = 0; i <= N_EVT; i++) begin
                r_cnt[i]    <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_sat   <= w_sat_next;
            if (snap_req_i) begin
                r_valid <= 1'b1;
                for (int i = 0; i <= N_EVT; i++) r_shadow[i] <= r_cnt[i];
            end
            for (int i = 0; i <= N_EVT; i++) r_cnt[i] <= w_cnt_next[i];
        end
    end

    always_comb begin
        snap_data_o = '0;
        for (int i = 0; i <= N_EVT; i++) begin
            if (snap_sel_i == SEL_W'(i)) snap_data_o = r_shadow[i];
        end
    end

    assign snap_valid_o = r_valid;
    assign cycle_o      = r_cnt[N_EVT];
    assign running_o    = (r_state == ST_RUN);
    assign done_o       = (r_state == ST_DONE);
    assign sat_o        = r_sat;

endmodule

// File: tb/tb_pipe_perf_counter.sv
// Bench for pipe_perf_counter: a default instance (32-bit, limit 30) and a narrow
// saturating instance (4-bit, unlimited) share stimulus and are checked against a model.
module tb_pipe_perf_counter;

    localparam int MS_IDLE = 0;
    localparam int MS_RUN  = 1;
    localparam int MS_DONE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] evt = 4'h0;
    logic       snap = 1'b0;
    logic [3:0] sel = 4'h0;

    logic [31:0] d_data, d_cycle;
    logic        d_valid, d_run, d_done;
    logic [4:0]  d_sat;
    logic [3:0]  s_data, s_cycle;
    logic        s_valid, s_run, s_done;
    logic [4:0]  s_sat;

    int checks = 0;
    int errors = 0;
    int ticks  = 0;

    longint m_cnt [2][5];
    longint m_sh  [2][5];
    bit [4:0] m_sat [2];
    bit     m_valid [2];
    int     m_st    [2];
    longint m_max   [2] = '{64'h0000_0000_FFFF_FFFF, 64'd15};
    longint m_lim   [2] = '{64'd30, 64'd0};

    always #5 clk = ~clk;

    pipe_perf_counter #(.CNT_W(32), .N_EVT(4), .MAX_CYCLES(30), .SEL_W(4)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clear), .evt_i(evt),
        .snap_req_i(snap), .snap_sel_i(sel), .snap_data_o(d_data), .snap_valid_o(d_valid),
        .cycle_o(d_cycle), .running_o(d_run), .done_o(d_done), .sat_o(d_sat)
    );

    pipe_perf_counter #(.CNT_W(4), .N_EVT(4), .MAX_CYCLES(0), .SEL_W(4)) u_sat (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clear), .evt_i(evt),
        .snap_req_i(snap), .snap_sel_i(sel), .snap_data_o(s_data), .snap_valid_o(s_valid),
        .cycle_o(s_cycle), .running_o(s_run), .done_o(s_done), .sat_o(s_sat)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int i);
        for (int k = 0; k < 5; k++) begin
            m_cnt[i][k] = 0;
            m_sh[i][k]  = 0;
        end
        m_sat[i]   = '0;
        m_valid[i] = 1'b0;
        m_st[i]    = MS_IDLE;
    endtask

    // One clock edge of the documented behaviour, using the inputs present at the edge.
    task automatic model_step(input int i);
        if (clear) begin
            model_clear(i);
        end else begin
            if (snap) begin
                for (int k = 0; k < 5; k++) m_sh[i][k] = m_cnt[i][k];
                m_valid[i] = 1'b1;
            end
            if (m_st[i] == MS_RUN) begin
                for (int k = 0; k < 5; k++) begin
                    if (k == 4 || evt[k]) begin
                        if (m_cnt[i][k] == m_max[i]) m_sat[i][k] = 1'b1;
                        else                         m_cnt[i][k]++;
                    end
                end
                if (m_lim[i] != 0 && m_cnt[i][4] == m_lim[i]) m_st[i] = MS_DONE;
                else if (!start)                            m_st[i] = MS_IDLE;
            end else if (m_st[i] == MS_IDLE && start) begin
                m_st[i] = MS_RUN;
            end
        end
    endtask

    function automatic longint model_snap(input int i, input int s);
        if (s <= 4) return m_sh[i][s];
        return 0;
    endfunction

    task automatic check_all();
        chk("d.cycle", 64'(d_cycle), m_cnt[0][4]);
        chk("d.running", 64'(d_run), 64'(m_st[0] == MS_RUN));
        chk("d.done", 64'(d_done), 64'(m_st[0] == MS_DONE));
        chk("d.sat", 64'(d_sat), 64'(m_sat[0]));
        chk("d.valid", 64'(d_valid), 64'(m_valid[0]));
        chk("d.snap_data", 64'(d_data), model_snap(0, int'(sel)));
        chk("s.cycle", 64'(s_cycle), m_cnt[1][4]);
        chk("s.running", 64'(s_run), 64'(m_st[1] == MS_RUN));
        chk("s.done", 64'(s_done), 64'(m_st[1] == MS_DONE));
        chk("s.sat", 64'(s_sat), 64'(m_sat[1]));
        chk("s.valid", 64'(s_valid), 64'(m_valid[1]));
        chk("s.snap_data", 64'(s_data), model_snap(1, int'(sel)));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) model_clear(i);
            else        model_step(i);
        end
        #1;
        ticks++;
        $display("tick %0d rst_n=%0b start=%0b clear=%0b snap=%0b evt=%h sel=%0d | d.cyc=%0d d.run=%0b d.done=%0b s.cyc=%0d s.sat=%b",
                 ticks, rst_n, start, clear, snap, evt, sel, d_cycle, d_run, d_done, s_cycle, s_sat);
        check_all();
    endtask

    initial begin
        model_clear(0);
        model_clear(1);

        // Reset held with start and all events high: everything stays zero.
        #2;
        rst_n = 1'b0;
        start = 1'b1;
        evt   = 4'hF;
        #1;
        check_all();
        repeat (3) tick();
        chk("rst.running", 64'(d_run), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel.running", 64'(d_run), 64'd1);
        chk("rel.cycle", 64'(d_cycle), 64'd0);

        // Auto-stop at 30 cycles; evt1 on every third run edge.
        for (int i = 0; i < 30; i++) begin
            evt = {2'b00, (i % 3 == 0), 1'b1};
            tick();
        end
        chk("limit.done", 64'(d_done), 64'd1);
        chk("limit.cycle", 64'(d_cycle), 64'd30);
        repeat (5) begin
            evt = 4'(($urandom));
            tick();
        end
        snap = 1'b1;
        tick();
        snap = 1'b0;
        sel = 4'd0; #1; chk("limit.evt0", 64'(d_data), 64'd30);
        sel = 4'd1; #1; chk("limit.evt1", 64'(d_data), 64'd10);
        sel = 4'd4; #1; chk("limit.cyc_shadow", 64'(d_data), 64'd30);

        // Pause: 7 run edges, 4 paused, 3 more with start high.
        clear = 1'b1; start = 1'b0; evt = 4'h0;
        tick();
        clear = 1'b0; start = 1'b1;
        tick();
        repeat (7) tick();
        start = 1'b0;
        repeat (4) begin
            tick();
            chk("pause.running", 64'(d_run), 64'd0);
        end
        start = 1'b1;
        repeat (3) tick();
        chk("pause.cycle", 64'(d_cycle), 64'd10);

        // Saturation on the 4-bit instance.
        clear = 1'b1; start = 1'b0;
        tick();
        clear = 1'b0; start = 1'b1; evt = 4'b0100;
        tick();
        repeat (20) tick();
        snap = 1'b1;
        tick();
        snap = 1'b0;
        chk("sat.cycle", 64'(s_cycle), 64'd15);
        chk("sat.flags", 64'(s_sat), 64'b10100);
        sel = 4'd2; #1; chk("sat.evt2", 64'(s_data), 64'd15);

        // Snapshot at cycle 12 stays frozen while the live count moves on.
        clear = 1'b1; start = 1'b0;
        tick();
        clear = 1'b0; start = 1'b1; evt = 4'b0001;
        tick();
        repeat (12) tick();
        chk("snap.live12", 64'(d_cycle), 64'd12);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        repeat (3) tick();
        sel = 4'd4; #1; chk("snap.cyc", 64'(d_data), 64'd12);
        sel = 4'd0; #1; chk("snap.evt0", 64'(d_data), 64'd12);
        chk("snap.valid", 64'(d_valid), 64'd1);
        sel = 4'd5; #1; chk("snap.sel_oor", 64'(d_data), 64'd0);

        // Clear and snapshot on the same edge: clear wins.
        clear = 1'b1; snap = 1'b1;
        tick();
        clear = 1'b0; snap = 1'b0;
        chk("conf.valid", 64'(d_valid), 64'd0);
        chk("conf.running", 64'(d_run), 64'd0);
        sel = 4'd0; #1; chk("conf.sh0", 64'(d_data), 64'd0);
        sel = 4'd4; #1; chk("conf.sh4", 64'(d_data), 64'd0);

        // Asynchronous reset between edges mid-RUN.
        start = 1'b1; evt = 4'hF;
        repeat (5) tick();
        #1;
        rst_n = 1'b0;
        #1;
        model_clear(0);
        model_clear(1);
        chk("arst.running", 64'(d_run), 64'd0);
        chk("arst.cycle", 64'(d_cycle), 64'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            start = ($urandom_range(0, 9) < 8);
            clear = ($urandom_range(0, 99) < 3);
            snap  = ($urandom_range(0, 9) == 0);
            evt   = 4'($urandom);
            sel   = 4'($urandom_range(0, 7));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
